// File: rtl/gates_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gates_test_pkg
// Description : Shared types, constants and the expected-response function
//               for the AND/OR/NOT gate unit self-test engine.
// Revision    : 1.0 - initial release
// ============================================================================
package gates_test_pkg;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of input vectors in one sweep: (a,b) = 00, 01, 10, 11
    localparam int NUM_VEC = 4;

    // Index of the final vector, in the width of the vector register
    localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

    // Golden response of the gate unit: {AND, OR, NOT a}
    function automatic logic [2:0] exp_y(input logic a, input logic b);
        return {a & b, a | b, ~a};
    endfunction

endpackage : gates_test_pkg
`default_nettype wire

// File: rtl/gates_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : gates_ref_model
// Description : Combinational expected-value model of the AND/OR/NOT gate
//               unit. Used by the self-test CHECK step; reusable by benches.
// Revision    : 1.0 - initial release
// ============================================================================
module gates_ref_model
    import gates_test_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    output logic [2:0] o_y
);

    // Expected gate outputs for the applied vector
    always_comb begin
        o_y = exp_y(i_a, i_b);
    end

endmodule : gates_ref_model
`default_nettype wire

// File: rtl/gates_selftest.sv
`default_nettype none
// ============================================================================
// Module      : gates_selftest
// Description : Sequential stimulus-and-check engine for the AND/OR/NOT gate
//               unit. One start pulse sweeps all four (a,b) vectors, holds
//               each for HOLD_CYCLES cycles, samples y, and reports pass,
//               mismatch count and a per-vector failure mask.
// Revision    : 1.0 - initial release
// ============================================================================
module gates_selftest
    import gates_test_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,   // cycles a vector is driven before y is sampled (1..255)
    parameter int CNT_W       = 8    // hold counter width; must hold HOLD_CYCLES-1
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [2:0] i_y,
    output logic       o_a,
    output logic       o_b,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [2:0] o_err_count,
    output logic [3:0] o_fail_mask
);

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    // Registered state and outputs
    state_t           r_state;
    logic [1:0]       r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [2:0]       r_err;
    logic [3:0]       r_mask;

    // Next-state values
    state_t           w_state;
    logic [1:0]       w_vec;
    logic [CNT_W-1:0] w_cnt;
    logic             w_a;
    logic             w_b;
    logic             w_busy;
    logic             w_done;
    logic             w_pass;
    logic [2:0]       w_err;
    logic [3:0]       w_mask;

    // Compare path
    logic [2:0]       w_exp_y;
    logic             w_mismatch;

    // Expected response is formed from the registered a/b actually on the pins
    gates_ref_model u_ref (
        .i_a (r_a),
        .i_b (r_b),
        .o_y (w_exp_y)
    );

    // Case-inequality so an undriven or X gate output is reported as a failure
    assign w_mismatch = (i_y !== w_exp_y);

    // State and output registers; reset discards any partial sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_vec   <= 2'd0;
            r_cnt   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
            r_mask  <= 4'd0;
        end else begin
            r_state <= w_state;
            r_vec   <= w_vec;
            r_cnt   <= w_cnt;
            r_a     <= w_a;
            r_b     <= w_b;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_err   <= w_err;
            r_mask  <= w_mask;
        end
    end

    // Next-state and next-output logic; all outputs are registered from here
    always_comb begin
        w_state = r_state;
        w_vec   = r_vec;
        w_cnt   = r_cnt;
        w_a     = r_a;
        w_b     = r_b;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_pass  = r_pass;
        w_err   = r_err;
        w_mask  = r_mask;

        case (r_state)
            IDLE: begin
                w_a    = 1'b0;
                w_b    = 1'b0;
                w_busy = 1'b0;
                if (i_start) begin
                    w_state = DRIVE;
                    w_vec   = 2'd0;
                    w_cnt   = '0;
                    w_err   = 3'd0;
                    w_mask  = 4'd0;
                    w_pass  = 1'b0;
                    w_busy  = 1'b1;
                end
            end

            DRIVE: begin
                w_a = r_vec[1];
                w_b = r_vec[0];
                if (r_cnt == C_HOLD_LAST) begin
                    w_state = CHECK;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            CHECK: begin
                if (w_mismatch) begin
                    w_mask[r_vec] = 1'b1;
                    w_err         = r_err + 3'd1;
                end
                if (r_vec == LAST_VEC) begin
                    // Pass is decided on the count that includes this last check
                    w_state = DONE;
                    w_a     = 1'b0;
                    w_b     = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_pass  = (w_err == 3'd0);
                end else begin
                    w_state = DRIVE;
                    w_vec   = r_vec + 2'd1;
                    w_cnt   = '0;
                    w_a     = w_vec[1];
                    w_b     = w_vec[0];
                end
            end

            DONE: begin
                w_state = IDLE;
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign o_a         = r_a;
    assign o_b         = r_b;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_count = r_err;
    assign o_fail_mask = r_mask;

endmodule : gates_selftest
`default_nettype wire
